// File: rtl/nrad_seq_divider.sv
// Sequential unsigned non-restoring divider. It has one row of M+1 add/subtract cells and
// produces one quotient bit per clock, with a start/busy/done handshake and divide-by-zero flag.
module nrad_seq_divider #(
  parameter int unsigned N = 8,
  parameter int unsigned M = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [N-1:0] dividend_i,
  input  logic [M-1:0] divisor_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [N-1:0] quotient_o,
  output logic [M-1:0] remainder_o,
  output logic         div_by_zero_o
);

  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {StIdle, StIter, StFix} state_e;

  state_e        state_q;
  logic [M:0]    p_q;
  logic [N-1:0]  q_q;
  logic [M-1:0]  d_q;
  logic [CW-1:0] count_q;

  logic [M:0] d_ext;
  logic [M:0] p_shift;
  logic [M:0] p_iter_d;
  logic [M:0] p_fix_d;

  // P is only M+1 bits wide. The shift can drop the top bit, but the wrapped sum is still
  // exact because every true partial remainder lies in [-D, D).
  always_comb begin
    d_ext    = {1'b0, d_q};
    p_shift  = {p_q[M-1:0], q_q[N-1]};
    p_iter_d = p_q[M] ? (p_shift + d_ext) : (p_shift - d_ext);
    p_fix_d  = p_q[M] ? (p_q + d_ext) : p_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      p_q           <= '0;
      q_q           <= '0;
      d_q           <= '0;
      count_q       <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      quotient_o    <= '0;
      remainder_o   <= '0;
      div_by_zero_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start_i) begin
            if (divisor_i != '0) begin
              d_q           <= divisor_i;
              p_q           <= '0;
              q_q           <= dividend_i;
              count_q       <= CW'(N);
              busy_o        <= 1'b1;
              div_by_zero_o <= 1'b0;
              state_q       <= StIter;
            end else begin
              done_o        <= 1'b1;
              div_by_zero_o <= 1'b1;
              quotient_o    <= '1;
              remainder_o   <= '0;
            end
          end
        end
        StIter: begin
          p_q     <= p_iter_d;
          q_q     <= {q_q[N-2:0], ~p_iter_d[M]};
          count_q <= count_q - CW'(1);
          if (count_q == CW'(1)) begin
            state_q <= StFix;
          end
        end
        StFix: begin
          remainder_o <= p_fix_d[M-1:0];
          quotient_o  <= q_q;
          done_o      <= 1'b1;
          busy_o      <= 1'b0;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_nrad_seq_divider.sv
// Scoreboard bench for nrad_seq_divider: expected results are queued at issue and
// checked by per-instance monitors whenever done is seen.
module tb_nrad_seq_divider;
  localparam int N  = 8;
  localparam int M  = 4;
  localparam int N2 = 4;
  localparam int M2 = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic         start = 1'b0;
  logic [N-1:0] dividend = '0;
  logic [M-1:0] divisor = '0;
  logic         busy, done, dz;
  logic [N-1:0] quotient;
  logic [M-1:0] remainder;

  logic          start2 = 1'b0;
  logic [N2-1:0] dividend2 = '0;
  logic [M2-1:0] divisor2 = '0;
  logic          busy2, done2, dz2;
  logic [N2-1:0] quotient2;
  logic [M2-1:0] remainder2;

  typedef struct packed {logic [N-1:0] q; logic [M-1:0] r; logic dz;} exp_t;
  typedef struct packed {logic [N2-1:0] q; logic [M2-1:0] r; logic dz;} exp2_t;

  exp_t  sb[$];
  exp2_t sb2[$];
  exp_t  e1;
  exp2_t e2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  nrad_seq_divider #(.N(N), .M(M)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start),
    .dividend_i   (dividend),
    .divisor_i    (divisor),
    .busy_o       (busy),
    .done_o       (done),
    .quotient_o   (quotient),
    .remainder_o  (remainder),
    .div_by_zero_o(dz)
  );

  nrad_seq_divider #(.N(N2), .M(M2)) dut2 (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start2),
    .dividend_i   (dividend2),
    .divisor_i    (divisor2),
    .busy_o       (busy2),
    .done_o       (done2),
    .quotient_o   (quotient2),
    .remainder_o  (remainder2),
    .div_by_zero_o(dz2)
  );

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL spurious_done q=%0d r=%0d dz=%0d", quotient, remainder, dz);
      end else begin
        e1 = sb.pop_front();
        if (quotient !== e1.q || remainder !== e1.r || dz !== e1.dz) begin
          failures++;
          $display("FAIL result8x4 actual q=%0d r=%0d dz=%0d required q=%0d r=%0d dz=%0d",
                   quotient, remainder, dz, e1.q, e1.r, e1.dz);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done2) begin
      checks++;
      if (sb2.size() == 0) begin
        failures++;
        $display("FAIL spurious_done2 q=%0d r=%0d dz=%0d", quotient2, remainder2, dz2);
      end else begin
        e2 = sb2.pop_front();
        if (quotient2 !== e2.q || remainder2 !== e2.r || dz2 !== e2.dz) begin
          failures++;
          $display("FAIL result4x2 actual q=%0d r=%0d dz=%0d required q=%0d r=%0d dz=%0d",
                   quotient2, remainder2, dz2, e2.q, e2.r, e2.dz);
        end
      end
    end
  end

  // Drives start for one edge; exp=0 means the request is expected to be ignored.
  task automatic issue1(input int a, input int b, input bit exp = 1'b1);
    exp_t e;
    start    = 1'b1;
    dividend = N'(a);
    divisor  = M'(b);
    if (b == 0) begin
      e.q = '1; e.r = '0; e.dz = 1'b1;
    end else begin
      e.q = N'(a / b); e.r = M'(a % b); e.dz = 1'b0;
    end
    if (exp) sb.push_back(e);
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = N'($urandom);
    divisor  = M'($urandom);
  endtask

  task automatic issue2(input int a, input int b);
    exp2_t e;
    start2    = 1'b1;
    dividend2 = N2'(a);
    divisor2  = M2'(b);
    if (b == 0) begin
      e.q = '1; e.r = '0; e.dz = 1'b1;
    end else begin
      e.q = N2'(a / b); e.r = M2'(a % b); e.dz = 1'b0;
    end
    sb2.push_back(e);
    @(posedge clk);
    #1;
    start2    = 1'b0;
    dividend2 = N2'($urandom);
    divisor2  = M2'($urandom);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0 && sb2.size() == 0) break;
      @(negedge clk);
    end
    if (sb.size() != 0 || sb2.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL timeout_%s pending=%0d required=0", name, sb.size() + sb2.size());
      sb.delete();
      sb2.delete();
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_quotient"}, quotient, 0);
    chk({tag, "_remainder"}, remainder, 0);
    chk({tag, "_dz"}, dz, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bcount, done_k, dcount, a, b;
    int pairs[4][2];
    pairs = '{'{255, 15}, '{5, 9}, '{0, 1}, '{255, 1}};

    #12;
    chk_zero("reset");
    rst_n = 1'b1;

    // 200/7: busy width and done latency
    @(negedge clk);
    issue1(200, 7);
    bcount = 0;
    done_k = -1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (busy) bcount++;
      if (done && done_k < 0) done_k = k;
    end
    chk("busy_cycles", bcount, N + 1);
    chk("done_latency", done_k, N + 1);

    foreach (pairs[i]) begin
      issue1(pairs[i][0], pairs[i][1]);
      wait_idle("directed");
    end

    // Divide by zero completes on the accept edge without busy
    issue1(77, 0);
    @(negedge clk);
    chk("dz_done_next_edge", done, 1);
    bcount = 0;
    for (int k = 0; k < 4; k++) begin
      if (busy) bcount++;
      @(negedge clk);
    end
    chk("dz_busy_never", bcount, 0);
    wait_idle("dz");

    // Mid-run start ignored, then back-to-back start on the done cycle
    issue1(200, 7);
    repeat (3) @(posedge clk);
    #1;
    issue1(9, 3, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    issue1(9, 3);
    wait_idle("b2b");

    // Asynchronous reset mid-run
    issue1(200, 7);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("no_done_after_rst", dcount, 0);
    issue1(100, 6);
    wait_idle("post_rst");

    // Exhaustive sweep, issued back-to-back at full throughput
    @(posedge clk);
    #1;
    for (int x = 0; x < 256; x++) begin
      for (int y = 1; y < 16; y++) begin
        issue1(x, y);
        repeat (N + 1) @(posedge clk);
        #1;
      end
    end
    wait_idle("sweep");

    // Random operands including divide by zero, with random gaps
    @(posedge clk);
    #1;
    for (int i = 0; i < 400; i++) begin
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 15));
      issue1(a, b);
      if (b != 0) repeat (N + 1) @(posedge clk);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    wait_idle("random");

    // Narrow 4/2 configuration against the legacy array results
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 4; y++) begin
        issue2(x, y);
        wait_idle("narrow");
      end
    end

    chk("scoreboard_drained", sb.size() + sb2.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
